// File: rtl/crc8_frame_insert.sv
// CRC-8 frame insertion stage for the 64b/66b transmit path: passes blocks through
// one output register and appends a control block carrying the CRC after each frame.
module crc8_frame_insert #(
  parameter int          FRAME_BLOCKS = 8,
  parameter int          CNT_W        = $clog2(FRAME_BLOCKS + 1),
  parameter logic [7:0]  POLY         = 8'h07,
  parameter logic [7:0]  INIT         = 8'h00,
  parameter logic [7:0]  CRC_TYPE     = 8'h4B
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [63:0]      payload_in,
  input  logic [1:0]       header_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [63:0]      payload_out,
  output logic [1:0]       header_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             crc_ins_out,
  output logic             hdr_err_out,
  output logic [CNT_W-1:0] frame_cnt_out
);

  // state | meaning
  // IDLE  | passing blocks, accumulating CRC
  // PEND  | frame complete; CRC block waits for the output register
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BLOCKS - 1);

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [63:0]        payload_q, payload_d;
  logic [1:0]         header_q, header_d;
  logic               ins_q, ins_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         crc_q, crc_d;
  logic [7:0]         crc_lat_q, crc_lat_d;
  logic [7:0]         crc_nxt;
  logic               out_free;
  logic               accept;

  // MSB-first, one bit per iteration, fully unrolled into a single-cycle step
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [63:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_nxt   = crc_step(crc_q, payload_in);
  assign out_free  = !valid_q || ready_in;
  assign ready_out = (state_q == IDLE) && out_free;
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    header_d  = header_q;
    ins_d     = ins_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    crc_lat_d = crc_lat_q;
    if (state_q == PEND) begin
      if (out_free) begin
        valid_d   = 1'b1;
        header_d  = 2'b10;
        payload_d = {CRC_TYPE, 48'h0, crc_lat_q};
        ins_d     = 1'b1;
        state_d   = IDLE;
      end
    end else if (accept) begin
      valid_d   = 1'b1;
      header_d  = header_in;
      payload_d = payload_in;
      ins_d     = 1'b0;
      if (header_in == 2'b01 && en_in) begin
        if (cnt_q == LAST) begin
          state_d   = PEND;
          crc_lat_d = crc_nxt;
          cnt_d     = '0;
          crc_d     = INIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          crc_d = crc_nxt;
        end
      end
      if (header_in == 2'b00 || header_in == 2'b11) err_d = 1'b1;
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      payload_q <= '0;
      header_q  <= '0;
      ins_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      crc_q     <= INIT;
      crc_lat_q <= INIT;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      header_q  <= header_d;
      ins_q     <= ins_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      crc_lat_q <= crc_lat_d;
    end
  end

  assign valid_out     = valid_q;
  assign payload_out   = payload_q;
  assign header_out    = header_q;
  assign crc_ins_out   = valid_q && ins_q && ready_in;
  assign hdr_err_out   = err_q;
  assign frame_cnt_out = cnt_q;

endmodule

// File: doc/crc8_frame_insert.md
Name: crc8_frame_insert

Overview:
- Parametrised successor to the single-block CRC-8 insertion stage in the 64b/66b transmit path.
- Accumulates a CRC-8 over a frame of FRAME_BLOCKS data blocks, header 2'b01.
- After the last data block of each frame, inserts one control block (header 2'b10) carrying the CRC.
- Sits between the block source and the scrambler. Valid/ready handshake on both sides; one output register stage.

Parameters:
- FRAME_BLOCKS, 8: data blocks covered per CRC block (1..65535).
- CNT_W, $clog2(FRAME_BLOCKS+1): width of the frame counter output.
- POLY, 8'h07: CRC-8 polynomial, implicit x^8.
- INIT, 8'h00: CRC register value at reset and at each frame start.
- CRC_TYPE, 8'h4B: block type byte placed in the inserted control block.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- en_in  in  1  1 = CRC accumulation/insertion on; 0 = pure passthrough.
- payload_in  in  64  input block payload.
- header_in  in  2  input sync header.
- valid_in  in  1  input block valid.
- ready_out  out  1  block accepted when valid_in & ready_out.
- payload_out  out  64  output block payload.
- header_out  out  2  output sync header.
- valid_out  out  1  output block valid.
- ready_in  in  1  downstream ready; transfer when valid_out & ready_in.
- crc_ins_out  out  1  one-cycle pulse on the cycle an inserted CRC block transfers out.
- hdr_err_out  out  1  sticky; set by accepting header 2'b00/2'b11; cleared only by reset.
- frame_cnt_out  out  CNT_W  data blocks accumulated in the current frame.

Behaviour:
- Reset (rst_in=0, async): valid_out=0, payload_out=0, header_out=0, crc_ins_out=0, hdr_err_out=0, frame_cnt_out=0, CRC register=INIT, pending=0. Any in-flight block or pending insertion is discarded.
- ready_out = !pending & (!valid_out | ready_in).
- Accepted block: loaded into the output register the same edge; latency 1 cycle. Header/payload are never modified on passthrough.
- valid_out holds with stable data until transfer.
- CRC definition: MSB-first over payload[63:0] (byte 63:56 first); no reflection, no final XOR. One 64-bit block per cycle via an unrolled combinational step.
- Data block accepted with en_in=1:
  - crc_next = step(crc, payload_in); counter+1.
  - If counter reaches FRAME_BLOCKS: pending=1, crc latched, counter cleared to 0, CRC register reset to INIT.
- Control block (10), or any block with en_in=0: passes through; CRC and counter are held (frame pauses and resumes when en_in returns).
- Header 00/11: passes through, not covered, sets hdr_err_out.
- Insertion state machine:
  - States: IDLE, PEND.
  - IDLE->PEND on the accept of the last frame block.
  - In PEND: ready_out=0. When the output register frees (!valid_out | ready_in), load header=2'b10, payload={CRC_TYPE, 48'h0, crc}, valid_out=1.
  - The crc_ins_out pulse coincides with that block's out transfer.
  - PEND->IDLE on load.
- The CRC block always follows the last frame block back-to-back when ready_in is held 1. Minimum overhead is 1 cycle per frame.
- ready_in=0 stalls everything without loss or duplication.
- en_in is sampled only at accept. Deassertion while in PEND does not cancel the insertion.

Test Plan:
- FRAME_BLOCKS=1, ready_in=1, blocks 01/64'h1, 01/64'h0 -> out: 01/64'h1, then 10/64'h4B00_0000_0000_0007, then 01/64'h0, then 10/64'h4B00_0000_0000_0000; crc_ins_out pulses twice.
- FRAME_BLOCKS=8, 20 random data blocks with 3 control blocks interleaved -> control blocks unchanged; CRC blocks after data blocks 8 and 16 match the bench model; frame_cnt_out=4 at end.
- Random ready_in (50%) and valid_in throttling over 1000 blocks -> output equals model stream, no drop/duplicate; ready_out=0 whenever pending.
- en_in=0 for data blocks 3-5 of a frame -> those bypass CRC; insertion occurs after 8 enabled data blocks; CRC excludes bypassed payloads.
- Header 2'b11 block mid-frame -> passed through; hdr_err_out=1 and stays 1; counter unchanged.
- rst_in asserted while PEND with ready_in=0 -> outputs zero immediately; no CRC block after release; the next frame CRC starts from INIT.
